// File: rtl/control_unit_pkg.sv
// Shared encodings for the multi-cycle control unit: opcodes, FSM states and datapath mux selects.
package control_unit_pkg;

  localparam logic [3:0] OpRtype = 4'd0;
  localparam logic [3:0] OpAddi  = 4'd1;
  localparam logic [3:0] OpLw    = 4'd2;
  localparam logic [3:0] OpSw    = 4'd3;
  localparam logic [3:0] OpBeq   = 4'd4;
  localparam logic [3:0] OpBne   = 4'd5;
  localparam logic [3:0] OpJmp   = 4'd6;

  typedef enum logic [3:0] {
    StInit    = 4'd0,
    StFetch   = 4'd1,
    StDecode  = 4'd2,
    StExecR   = 4'd3,
    StRWb     = 4'd4,
    StExecI   = 4'd5,
    StIWb     = 4'd6,
    StMemAddr = 4'd7,
    StMemRd   = 4'd8,
    StMemWb   = 4'd9,
    StMemWr   = 4'd10,
    StBranch  = 4'd11,
    StJump    = 4'd12
  } cu_state_e;

  localparam logic [1:0] PcSrcAlu    = 2'd0;
  localparam logic [1:0] PcSrcAluOut = 2'd1;
  localparam logic [1:0] PcSrcJump   = 2'd2;

  localparam logic [1:0] AluBRt  = 2'd0;
  localparam logic [1:0] AluBTwo = 2'd1;
  localparam logic [1:0] AluBImm = 2'd2;

  localparam logic [1:0] AluOpAdd   = 2'd0;
  localparam logic [1:0] AluOpSub   = 2'd1;
  localparam logic [1:0] AluOpFunct = 2'd2;

  function automatic logic is_legal_op(logic [3:0] op);
    return op <= OpJmp;
  endfunction

endpackage

// File: rtl/control_unit_decode.sv
// Combinational decode of the current state into datapath control strobes.
module control_unit_decode
  import control_unit_pkg::*;
(
  input  logic [3:0] state_i,
  input  logic [3:0] opcode_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       pc_write_o,
  output logic [1:0] pc_source_o,
  output logic       i_or_d_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       ir_write_o,
  output logic       reg_write_o,
  output logic       reg_dst_o,
  output logic       mem_to_reg_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] alu_op_o
);

  always_comb begin
    pc_write_o   = 1'b0;
    pc_source_o  = PcSrcAlu;
    i_or_d_o     = 1'b0;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    ir_write_o   = 1'b0;
    reg_write_o  = 1'b0;
    reg_dst_o    = 1'b0;
    mem_to_reg_o = 1'b0;
    alu_src_a_o  = 1'b0;
    alu_src_b_o  = AluBRt;
    alu_op_o     = AluOpAdd;
    unique case (state_i)
      StFetch: begin
        mem_read_o  = 1'b1;
        alu_src_b_o = AluBTwo;
        // IR and PC+2 only commit once the fetch actually completes
        ir_write_o  = mem_ready_i;
        pc_write_o  = mem_ready_i;
      end
      StDecode: alu_src_b_o = AluBImm;
      StExecR: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = AluOpFunct;
      end
      StRWb: begin
        reg_dst_o   = 1'b1;
        reg_write_o = 1'b1;
      end
      StExecI, StMemAddr: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = AluBImm;
      end
      StIWb: reg_write_o = 1'b1;
      StMemRd: begin
        mem_read_o = 1'b1;
        i_or_d_o   = 1'b1;
      end
      StMemWb: begin
        mem_to_reg_o = 1'b1;
        reg_write_o  = 1'b1;
      end
      StMemWr: begin
        mem_write_o = 1'b1;
        i_or_d_o    = 1'b1;
      end
      StBranch: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = AluOpSub;
        pc_source_o = PcSrcAluOut;
        pc_write_o  = (opcode_i == OpBeq) ? zero_i : ~zero_i;
      end
      StJump: begin
        pc_source_o = PcSrcJump;
        pc_write_o  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle control FSM: state register, retired-instruction counter and sticky illegal flag.
module control_unit
  import control_unit_pkg::*;
#(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [3:0]  input_CU_opcode,
  input  logic        input_CU_zero,
  input  logic        input_CU_memReady,
  output logic        output_CU_PCWrite,
  output logic [1:0]  output_CU_PCSource,
  output logic        output_CU_IorD,
  output logic        output_CU_MemRead,
  output logic        output_CU_MemWrite,
  output logic        output_CU_IRWrite,
  output logic        output_CU_RegWrite,
  output logic        output_CU_RegDst,
  output logic        output_CU_MemtoReg,
  output logic        output_CU_ALUSrcA,
  output logic [1:0]  output_CU_ALUSrcB,
  output logic [1:0]  output_CU_ALUOp,
  output logic [3:0]  output_CU_state,
  output logic        output_CU_illegal,
  output logic [15:0] output_CU_instrCount
);

  cu_state_e   state_q, state_d;
  logic        illegal_q, illegal_d;
  logic [15:0] count_q, count_d;
  logic        mem_ready;

  assign mem_ready = MEM_WAIT_EN ? input_CU_memReady : 1'b1;

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    count_d   = count_q;
    unique case (state_q)
      StInit:  state_d = StFetch;
      StFetch: if (mem_ready) state_d = StDecode;
      StDecode: begin
        case (input_CU_opcode)
          OpRtype:     state_d = StExecR;
          OpAddi:      state_d = StExecI;
          OpLw, OpSw:  state_d = StMemAddr;
          OpBeq, OpBne: state_d = StBranch;
          OpJmp:       state_d = StJump;
          default:     state_d = StFetch;
        endcase
        if (!is_legal_op(input_CU_opcode)) illegal_d = 1'b1;
      end
      StExecR:   state_d = StRWb;
      StExecI:   state_d = StIWb;
      StMemAddr: state_d = (input_CU_opcode == OpLw) ? StMemRd : StMemWr;
      StMemRd:   if (mem_ready) state_d = StMemWb;
      StMemWr: begin
        if (mem_ready) begin
          state_d = StFetch;
          count_d = count_q + 16'd1;
        end
      end
      StRWb, StIWb, StMemWb, StBranch, StJump: begin
        state_d = StFetch;
        count_d = count_q + 16'd1;
      end
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= StInit;
      illegal_q <= 1'b0;
      count_q   <= 16'd0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      count_q   <= count_d;
    end
  end

  control_unit_decode u_decode (
    .state_i      (state_q),
    .opcode_i     (input_CU_opcode),
    .zero_i       (input_CU_zero),
    .mem_ready_i  (mem_ready),
    .pc_write_o   (output_CU_PCWrite),
    .pc_source_o  (output_CU_PCSource),
    .i_or_d_o     (output_CU_IorD),
    .mem_read_o   (output_CU_MemRead),
    .mem_write_o  (output_CU_MemWrite),
    .ir_write_o   (output_CU_IRWrite),
    .reg_write_o  (output_CU_RegWrite),
    .reg_dst_o    (output_CU_RegDst),
    .mem_to_reg_o (output_CU_MemtoReg),
    .alu_src_a_o  (output_CU_ALUSrcA),
    .alu_src_b_o  (output_CU_ALUSrcB),
    .alu_op_o     (output_CU_ALUOp)
  );

  assign output_CU_state      = state_q;
  assign output_CU_illegal    = illegal_q;
  assign output_CU_instrCount = count_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: walks each opcode through the FSM and checks strobes and latency.
module tb_control_unit;
  import control_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  opcode;
  logic        zero;
  logic        mem_ready;
  logic        pc_write, i_or_d, mem_read, mem_write, ir_write;
  logic        reg_write, reg_dst, mem_to_reg, alu_src_a, illegal;
  logic [1:0]  pc_source, alu_src_b, alu_op;
  logic [3:0]  state;
  logic [15:0] instr_count;

  int n_tests = 0;
  int n_fail  = 0;

  control_unit #(.MEM_WAIT_EN(1'b1)) dut (
    .CLK                  (clk),
    .RST_N                (rst_n),
    .input_CU_opcode      (opcode),
    .input_CU_zero        (zero),
    .input_CU_memReady    (mem_ready),
    .output_CU_PCWrite    (pc_write),
    .output_CU_PCSource   (pc_source),
    .output_CU_IorD       (i_or_d),
    .output_CU_MemRead    (mem_read),
    .output_CU_MemWrite   (mem_write),
    .output_CU_IRWrite    (ir_write),
    .output_CU_RegWrite   (reg_write),
    .output_CU_RegDst     (reg_dst),
    .output_CU_MemtoReg   (mem_to_reg),
    .output_CU_ALUSrcA    (alu_src_a),
    .output_CU_ALUSrcB    (alu_src_b),
    .output_CU_ALUOp      (alu_op),
    .output_CU_state      (state),
    .output_CU_illegal    (illegal),
    .output_CU_instrCount (instr_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction from a sampled FETCH back to FETCH; waits = memReady-low cycles in MEM_RD/WR.
  task automatic run_instr(input string name, input logic [3:0] op, input logic z,
                           input int waits, input int exp_cyc, input int exp_regw,
                           input int exp_inc, input logic exp_pcw);
    int          cyc   = 0;
    int          regw  = 0;
    int          left  = waits;
    logic        both  = 1'b0;
    logic [15:0] cnt0  = instr_count;
    opcode = op;
    zero   = z;
    forever begin
      if ((state == StMemRd || state == StMemWr) && left > 0) begin
        mem_ready = 1'b0;
        left--;
      end else begin
        mem_ready = 1'b1;
      end
      step();
      cyc++;
      if (mem_read && mem_write) both = 1'b1;
      if (reg_write) regw++;
      case (state)
        StExecR:  check_eq({name, "_execr_aluop"}, {30'd0, alu_op}, 32'd2);
        StRWb:    check_eq({name, "_rwb_regdst"}, {31'd0, reg_dst}, 32'd1);
        StIWb:    check_eq({name, "_iwb_regdst"}, {31'd0, reg_dst}, 32'd0);
        StMemRd:  check_eq({name, "_memrd_rd_iord"}, {30'd0, mem_read, i_or_d}, 32'd3);
        StMemWb:  check_eq({name, "_memwb_memtoreg"}, {31'd0, mem_to_reg}, 32'd1);
        StMemWr:  check_eq({name, "_memwr_wr_iord"}, {30'd0, mem_write, i_or_d}, 32'd3);
        StBranch: check_eq({name, "_branch_pcw_src"}, {29'd0, pc_write, pc_source}, {29'd0, exp_pcw, 2'd1});
        StJump:   check_eq({name, "_jump_pcw_src"}, {29'd0, pc_write, pc_source}, {29'd0, exp_pcw, 2'd2});
        default: ;
      endcase
      if (state == StFetch || cyc >= 20) break;
    end
    mem_ready = 1'b1;
    check_eq({name, "_cycles"}, cyc, exp_cyc);
    check_eq({name, "_regwrite_cycles"}, regw, exp_regw);
    check_eq({name, "_rd_wr_exclusive"}, {31'd0, both}, 32'd0);
    check_eq({name, "_count"}, {16'd0, instr_count}, {16'd0, cnt0 + 16'(exp_inc)});
  endtask

  initial begin
    rst_n     = 1'b0;
    opcode    = OpRtype;
    zero      = 1'b0;
    mem_ready = 1'b1;
    #2;
    check_eq("rst_state", {28'd0, state}, 32'd0);
    check_eq("rst_count", {16'd0, instr_count}, 32'd0);
    check_eq("rst_illegal", {31'd0, illegal}, 32'd0);
    check_eq("rst_strobes", {28'd0, mem_read, mem_write, pc_write, reg_write}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_eq("fetch_state", {28'd0, state}, 32'd1);
    check_eq("fetch_ctl", {26'd0, mem_read, ir_write, pc_write, pc_source, i_or_d},
             {26'd0, 1'b1, 1'b1, 1'b1, 2'd0, 1'b0});
    check_eq("fetch_alu", {27'd0, alu_src_a, alu_src_b, alu_op}, {27'd0, 1'b0, 2'd1, 2'd0});

    run_instr("rtype", OpRtype, 1'b0, 0, 4, 1, 1, 1'b0);
    run_instr("lw_wait", OpLw, 1'b0, 2, 7, 1, 1, 1'b0);
    run_instr("sw", OpSw, 1'b0, 0, 4, 0, 1, 1'b0);
    run_instr("addi", OpAddi, 1'b0, 0, 4, 1, 1, 1'b0);
    run_instr("beq_z1", OpBeq, 1'b1, 0, 3, 0, 1, 1'b1);
    run_instr("beq_z0", OpBeq, 1'b0, 0, 3, 0, 1, 1'b0);
    run_instr("bne_z0", OpBne, 1'b0, 0, 3, 0, 1, 1'b1);
    run_instr("bne_z1", OpBne, 1'b1, 0, 3, 0, 1, 1'b0);
    run_instr("jmp", OpJmp, 1'b0, 0, 3, 0, 1, 1'b1);
    check_eq("after_jmp_fetch", {29'd0, pc_write, pc_source}, {29'd0, 1'b1, 2'd0});
    check_eq("no_illegal_yet", {31'd0, illegal}, 32'd0);

    run_instr("illegal9", 4'd9, 1'b0, 0, 2, 0, 0, 1'b0);
    check_eq("illegal_set", {31'd0, illegal}, 32'd1);
    run_instr("add_after_ill", OpRtype, 1'b0, 0, 4, 1, 1, 1'b0);
    check_eq("illegal_sticky", {31'd0, illegal}, 32'd1);
    check_eq("count_total", {16'd0, instr_count}, 32'd10);

    // FETCH stall: no IR/PC update while memory is busy
    mem_ready = 1'b0;
    #1;
    check_eq("fetch_stall_gate", {29'd0, mem_read, ir_write, pc_write}, 32'd4);
    step();
    check_eq("fetch_stall_hold", {28'd0, state}, 32'd1);
    mem_ready = 1'b1;

    // Asynchronous reset while a store is waiting on memory
    opcode = OpSw;
    step();
    step();
    mem_ready = 1'b0;
    step();
    check_eq("memwr_active", {28'd0, state}, {28'd0, StMemWr});
    check_eq("memwr_strobe", {31'd0, mem_write}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_memwrite", {31'd0, mem_write}, 32'd0);
    check_eq("async_rst_state", {28'd0, state}, 32'd0);
    check_eq("async_rst_count", {16'd0, instr_count}, 32'd0);
    check_eq("async_rst_illegal", {31'd0, illegal}, 32'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    mem_ready = 1'b1;
    step();
    check_eq("post_rst_fetch", {28'd0, state}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 MEM_WAIT_EN, default 1, meaning: 1 = FETCH/MEM_RD/MEM_WR hold until memReady; 0 = memReady treated as constant 1.
REQ-002 CLK  input  1  system clock; all state updates on rising edge.
REQ-003 RST_N  input  1  reset, asynchronous, active-low.
REQ-004 input_CU_opcode  input  4  IR[15:12].
REQ-005 input_CU_zero  input  1  ALU zero flag.
REQ-006 input_CU_memReady  input  1  memory access complete this cycle.
REQ-007 output_CU_PCWrite  output  1  drives input_PC_PCWrite.
REQ-008 output_CU_PCSource  output  2  0 ALU result (PC+2), 1 ALUOut (branch target), 2 jump target.
REQ-009 output_CU_IorD  output  1  memory address: 0 PC, 1 ALUOut.
REQ-010 output_CU_MemRead  output  1  memory read strobe.
REQ-011 output_CU_MemWrite  output  1  memory write strobe.
REQ-012 output_CU_IRWrite  output  1  instruction register load.
REQ-013 output_CU_RegWrite  output  1  register file write.
REQ-014 output_CU_RegDst  output  1  0 rt, 1 rd.
REQ-015 output_CU_MemtoReg  output  1  0 ALUOut, 1 MDR.
REQ-016 output_CU_ALUSrcA  output  1  0 PC, 1 rs.
REQ-017 output_CU_ALUSrcB  output  2  0 rt, 1 constant 2, 2 sign-extended imm.
REQ-018 output_CU_ALUOp  output  2  0 add, 1 sub, 2 funct-decoded.
REQ-019 output_CU_state  output  4  current state encoding (debug).
REQ-020 output_CU_illegal  output  1  sticky illegal-opcode flag.
REQ-021 output_CU_instrCount  output  16  retired-instruction count.

Function
REQ-022 Opcodes: 0 RTYPE, 1 ADDI, 2 LW, 3 SW, 4 BEQ, 5 BNE, 6 JMP, 7-15 illegal.
REQ-023 Outputs decoded from state register only; exceptions: IRWrite/FETCH-PCWrite gated by memReady, BRANCH-PCWrite gated by zero; unlisted outputs 0 in every state.
REQ-024 INIT: all outputs 0; -> FETCH.
REQ-025 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=1, ALUOp=0, PCSource=0; IRWrite=PCWrite=memReady; hold while !memReady; -> DECODE.
REQ-026 DECODE: ALUSrcA=0, ALUSrcB=2, ALUOp=0; -> EXEC_R (RTYPE), EXEC_I (ADDI), MEM_ADDR (LW/SW), BRANCH (BEQ/BNE), JUMP (JMP), FETCH (illegal, sets illegal).
REQ-027 EXEC_R: ALUSrcA=1, ALUSrcB=0, ALUOp=2 -> R_WB: RegDst=1, RegWrite=1 -> FETCH.
REQ-028 EXEC_I: ALUSrcA=1, ALUSrcB=2, ALUOp=0 -> I_WB: RegDst=0, RegWrite=1 -> FETCH.
REQ-029 MEM_ADDR: ALUSrcA=1, ALUSrcB=2, ALUOp=0 -> MEM_RD (LW) or MEM_WR (SW).
REQ-030 MEM_RD: MemRead=1, IorD=1; hold until memReady -> MEM_WB: MemtoReg=1, RegDst=0, RegWrite=1 -> FETCH.
REQ-031 MEM_WR: MemWrite=1, IorD=1; hold until memReady -> FETCH.
REQ-032 BRANCH: ALUSrcA=1, ALUSrcB=0, ALUOp=1, PCSource=1, PCWrite=zero (BEQ) or !zero (BNE) -> FETCH.
REQ-033 JUMP: PCSource=2, PCWrite=1 -> FETCH.
REQ-034 Latency FETCH-to-FETCH with memReady=1: BEQ/BNE/JMP 3, RTYPE/ADDI/SW 4, LW 5 cycles; +1 per wait cycle.
REQ-035 While holding in a wait state, all outputs stay constant; memReady outside FETCH/MEM_RD/MEM_WR ignored.
REQ-036 MemRead and MemWrite never both 1; RegWrite at most one cycle per instruction.
REQ-037 instrCount +1 on each transition into FETCH from R_WB, I_WB, MEM_WB, MEM_WR, BRANCH, JUMP; illegal path does not count; wraps FFFF->0000.
REQ-038 illegal set on DECODE->FETCH illegal transition; cleared only by reset.

Reset
REQ-039 RST_N low asynchronously forces INIT, all outputs 0, instrCount 0, illegal 0, without waiting for CLK.
REQ-040 Reset mid-instruction aborts it; no strobe remains asserted after assertion; first rising edge after deassertion moves INIT->FETCH.

Structure
REQ-041 Package control_unit_pkg holds opcode constants, 4-bit state encodings, PCSource/ALUSrcB/ALUOp encodings; shared with datapath and ALU control.
REQ-042 Optional sub-module control_unit_decode: combinational state/opcode/zero/memReady -> control outputs; state register, counter, flag stay in control_unit.

Verification
REQ-043 Reset, opcode 0, memReady=1 -> states INIT,FETCH,DECODE,EXEC_R,R_WB,FETCH; RegWrite=1, RegDst=1 only in R_WB; instrCount 0->1.
REQ-044 LW, memReady low 2 cycles in MEM_RD -> 7 cycles FETCH-to-FETCH; MemRead=1, IorD=1 stable 3 cycles; MemWrite=0 throughout; MemtoReg=1 in MEM_WB.
REQ-045 BEQ zero=1 -> BRANCH PCWrite=1, PCSource=1; BEQ zero=0 -> PCWrite=0; BNE zero=0 -> PCWrite=1.
REQ-046 JMP -> 3 cycles; JUMP PCWrite=1, PCSource=2; FETCH PCWrite=1, PCSource=0.
REQ-047 Opcode 9 -> DECODE->FETCH, illegal=1 and stays through following ADD; instrCount unchanged by opcode 9.
REQ-048 RST_N pulsed low between edges during MEM_WR -> MemWrite drops to 0 immediately; state INIT; instrCount 0.
